req_arbiter_4: RTL
==================

REQ_ARBITER_4 -- requirements
Module: req_arbiter_4

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum grant length in cycles before forced release; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req  input  4  request vector, bit i = requester i.
REQ-005 done  input  1  current owner releases the resource; ignored when no grant is active.
REQ-006 gnt  output  4  one-hot grant, registered; all zeros when no grant is active.
REQ-007 gnt_idx  output  2  binary index of the set gnt bit, registered.
REQ-008 gnt_vld  output  1  high when gnt holds a valid one-hot grant.
REQ-009 timeout  output  1  one-cycle pulse when a grant is force-released at HOLD_MAX.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (owner granted).
REQ-011 Internal state SHALL be: state, 2-bit rotation pointer ptr, 8-bit hold counter cnt, and 2-bit owner index.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with all outputs zero.
REQ-013 In IDLE with req!=0, the block SHALL select the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- gnt, gnt_idx and gnt_vld SHALL take the selection on the next edge (1-cycle latency).
- On the same edge the block SHALL enter BUSY and clear cnt to 0.
REQ-014 In BUSY, gnt, gnt_idx and gnt_vld SHALL hold constant; changes on other req bits SHALL NOT affect the grant.
REQ-015 In BUSY, cnt SHALL increment by 1 on each edge on which no release condition is true.
REQ-016 Release conditions in BUSY, evaluated each cycle:
- (a) done==1;
- (b) req[owner]==0;
- (c) cnt==HOLD_MAX-1.
REQ-017 When any release condition is true, the next edge SHALL:
- return to IDLE;
- clear gnt, gnt_idx and gnt_vld to zero;
- set ptr to (owner+1) mod 4.
REQ-018 timeout SHALL pulse high for exactly the one cycle after the release edge, only when (c) is true and both (a) and (b) are false.
REQ-019 Every grant SHALL be followed by at least one IDLE cycle with gnt_vld==0, so at most one owner is granted in any cycle.
REQ-020 ptr wraps 3 -> 0; the scan SHALL wrap within the 4-bit vector.
REQ-021 With all four requesters held high and done pulsed in every BUSY cycle, grants SHALL rotate 0,1,2,3,0,...
REQ-022 gnt SHALL be one-hot or all zeros in every cycle, and gnt_idx SHALL equal the binary encoding of gnt; gnt_idx==0 whenever gnt_vld==0.
REQ-023 The block SHALL contain no latches and no combinational path from inputs to outputs.

Reset
REQ-024 While rst is high, the block SHALL hold:
- state IDLE;
- ptr=0, cnt=0, owner=0;
- gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, timeout=0.
REQ-025 Assertion of rst during BUSY SHALL clear the grant immediately, without waiting for a clock edge.
REQ-026 After rst deasserts, the first grant SHALL start its scan from requester 0.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset, then req=4'b0100 -> one edge later gnt=4'b0100, gnt_idx=2, gnt_vld=1.
- req=4'b1111 held, done pulsed in each BUSY cycle -> gnt_idx sequence 0,1,2,3,0 with one gnt_vld=0 cycle between grants.
- HOLD_MAX=8, req=4'b0001 held, done=0 -> gnt_vld high for 8 cycles, then timeout=1 for one cycle, then regrant to 0 after the idle cycle.
- Owner 1 drops req[1] while req=4'b1010 -> release next edge, ptr=2, next grant gnt=4'b1000.
- In BUSY with owner 0, req changes 4'b0001 -> 4'b1111 -> gnt stays 4'b0001 until a release condition.
- rst asserted mid-BUSY between clock edges -> gnt=0 and gnt_vld=0 immediately; after release with req=4'b1110 the grant goes to 1 (ptr=0).

Source files
------------

// File: rtl/req_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, owner release on done or
// request drop, and forced release after hold_max cycles.

module req_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] owner_q, owner_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       timeout_q, timeout_d;

    logic [1:0] cand;
    logic [1:0] sel_idx;
    logic       found;
    logic       rel_done, rel_drop, rel_max, rel_any;

    // Scan from the farthest offset down so the nearest set bit after ptr wins.
    always_comb begin
        cand    = '0;
        sel_idx = '0;
        found   = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    assign rel_done = done;
    assign rel_drop = ~req[owner_q];
    assign rel_max  = (cnt_q == HoldLast);
    assign rel_any  = rel_done | rel_drop | rel_max;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d   = StBusy;
                    cnt_d     = '0;
                    owner_d   = sel_idx;
                    gnt_d     = 4'b0001 << sel_idx;
                    gnt_idx_d = sel_idx;
                    gnt_vld_d = 1'b1;
                end
            end
            StBusy: begin
                if (rel_any) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    ptr_d     = owner_q + 2'd1;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    gnt_vld_d = 1'b0;
                    // Only a pure hold-limit release is reported as a timeout.
                    timeout_d = rel_max & ~rel_done & ~rel_drop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cnt_q     <= '0;
            owner_q   <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule
